// File: rtl/video_timing.sv
// Raster timing master: issues hdata/vdata to the layer stack and drives VGA pins with latency-matched sync/blank.
// Optional colour-bar generator is built only when VT_TEST_PATTERN_EN is defined.
module video_timing #(
  parameter int DEPTH   = 4,
  parameter int HWIDTH  = 12,
  parameter int VWIDTH  = 12,
  parameter int HSIZE   = 640,
  parameter int HFP     = 16,
  parameter int HSYNC   = 96,
  parameter int HBP     = 48,
  parameter int VSIZE   = 480,
  parameter int VFP     = 10,
  parameter int VSYNC   = 2,
  parameter int VBP     = 33,
  parameter int LATENCY = 1,
  parameter logic [3*DEPTH-1:0] BG = 12'h000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  output logic [HWIDTH-1:0] hdata,
  output logic [VWIDTH-1:0] vdata,
  input  logic [DEPTH-1:0]  R_in,
  input  logic [DEPTH-1:0]  G_in,
  input  logic [DEPTH-1:0]  B_in,
  input  logic              A_in,
  input  logic              test_mode,
  output logic [DEPTH-1:0]  vga_r,
  output logic [DEPTH-1:0]  vga_g,
  output logic [DEPTH-1:0]  vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              frame_start
);

  localparam int HTOTAL = HSIZE + HFP + HSYNC + HBP;
  localparam int VTOTAL = VSIZE + VFP + VSYNC + VBP;
  localparam logic [HWIDTH-1:0] H_LAST = HWIDTH'(HTOTAL - 1);
  localparam logic [VWIDTH-1:0] V_LAST = VWIDTH'(VTOTAL - 1);
  localparam logic [HWIDTH-1:0] H_SIZE = HWIDTH'(HSIZE);
  localparam logic [VWIDTH-1:0] V_SIZE = VWIDTH'(VSIZE);
  localparam logic [HWIDTH-1:0] H_SS   = HWIDTH'(HSIZE + HFP);
  localparam logic [HWIDTH-1:0] H_SE   = HWIDTH'(HSIZE + HFP + HSYNC - 1);
  localparam logic [VWIDTH-1:0] V_SS   = VWIDTH'(VSIZE + VFP);
  localparam logic [VWIDTH-1:0] V_SE   = VWIDTH'(VSIZE + VFP + VSYNC - 1);

  logic [HWIDTH-1:0]  hcount_q, hcount_d;
  logic [VWIDTH-1:0]  vcount_q, vcount_d;
  logic               frame_start_q, frame_start_d;
  logic [3*DEPTH-1:0] rgb_q, rgb_d;
  logic               vga_hs_q, vga_hs_d, vga_vs_q, vga_vs_d;
  logic               active_raw, hs_raw_n, vs_raw_n;
  logic               active_dly, hs_dly_n, vs_dly_n;
`ifdef VT_TEST_PATTERN_EN
  logic [HWIDTH-1:0]  hcount_dly;
  logic [2:0]         bar_idx;
  logic [3*DEPTH-1:0] bar_rgb;
`else
  logic               unused_test_mode;
  assign unused_test_mode = test_mode;
`endif

  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    frame_start_d = 1'b0;
    if (tick) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        if (vcount_q == V_LAST) begin
          vcount_d      = '0;
          frame_start_d = 1'b1;
        end else begin
          vcount_d = vcount_q + 1'b1;
        end
      end else begin
        hcount_d = hcount_q + 1'b1;
      end
    end
  end

  assign active_raw = (hcount_q < H_SIZE) && (vcount_q < V_SIZE);
  assign hs_raw_n   = !((hcount_q >= H_SS) && (hcount_q <= H_SE));
  assign vs_raw_n   = !((vcount_q >= V_SS) && (vcount_q <= V_SE));

  // Sync/blank (and bar coordinate) follow the layer-stack read latency.
  if (LATENCY == 0) begin : g_direct
    assign active_dly = active_raw;
    assign hs_dly_n   = hs_raw_n;
    assign vs_dly_n   = vs_raw_n;
`ifdef VT_TEST_PATTERN_EN
    assign hcount_dly = hcount_q;
`endif
  end else begin : g_pipe
    logic [LATENCY-1:0] active_sr_q, active_sr_d;
    logic [LATENCY-1:0] hs_sr_q, hs_sr_d;
    logic [LATENCY-1:0] vs_sr_q, vs_sr_d;
`ifdef VT_TEST_PATTERN_EN
    logic [HWIDTH-1:0] hcount_sr_q [LATENCY];
    logic [HWIDTH-1:0] hcount_sr_d [LATENCY];
`endif

    always_comb begin
      active_sr_d = active_sr_q;
      hs_sr_d     = hs_sr_q;
      vs_sr_d     = vs_sr_q;
`ifdef VT_TEST_PATTERN_EN
      hcount_sr_d = hcount_sr_q;
`endif
      if (tick) begin
        active_sr_d[0] = active_raw;
        hs_sr_d[0]     = hs_raw_n;
        vs_sr_d[0]     = vs_raw_n;
`ifdef VT_TEST_PATTERN_EN
        hcount_sr_d[0] = hcount_q;
`endif
        for (int i = 1; i < LATENCY; i++) begin
          active_sr_d[i] = active_sr_q[i-1];
          hs_sr_d[i]     = hs_sr_q[i-1];
          vs_sr_d[i]     = vs_sr_q[i-1];
`ifdef VT_TEST_PATTERN_EN
          hcount_sr_d[i] = hcount_sr_q[i-1];
`endif
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        active_sr_q <= '0;
        hs_sr_q     <= '1;
        vs_sr_q     <= '1;
`ifdef VT_TEST_PATTERN_EN
        for (int i = 0; i < LATENCY; i++) hcount_sr_q[i] <= '0;
`endif
      end else begin
        active_sr_q <= active_sr_d;
        hs_sr_q     <= hs_sr_d;
        vs_sr_q     <= vs_sr_d;
`ifdef VT_TEST_PATTERN_EN
        hcount_sr_q <= hcount_sr_d;
`endif
      end
    end

    assign active_dly = active_sr_q[LATENCY-1];
    assign hs_dly_n   = hs_sr_q[LATENCY-1];
    assign vs_dly_n   = vs_sr_q[LATENCY-1];
`ifdef VT_TEST_PATTERN_EN
    assign hcount_dly = hcount_sr_q[LATENCY-1];
`endif
  end

`ifdef VT_TEST_PATTERN_EN
  // Eight equal-width bars across the visible line; index bits map straight to R/G/B.
  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++) begin
      if (hcount_dly >= HWIDTH'(k * (HSIZE / 8))) bar_idx = 3'(k);
    end
    bar_rgb = {{DEPTH{bar_idx[2]}}, {DEPTH{bar_idx[1]}}, {DEPTH{bar_idx[0]}}};
  end
`endif

  always_comb begin
    rgb_d    = rgb_q;
    vga_hs_d = vga_hs_q;
    vga_vs_d = vga_vs_q;
    if (tick) begin
      vga_hs_d = hs_dly_n;
      vga_vs_d = vs_dly_n;
      if (!active_dly) rgb_d = '0;
`ifdef VT_TEST_PATTERN_EN
      else if (test_mode) rgb_d = bar_rgb;
`endif
      else if (A_in) rgb_d = {R_in, G_in, B_in};
      else rgb_d = BG;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      frame_start_q <= 1'b0;
      rgb_q         <= '0;
      vga_hs_q      <= 1'b1;
      vga_vs_q      <= 1'b1;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      frame_start_q <= frame_start_d;
      rgb_q         <= rgb_d;
      vga_hs_q      <= vga_hs_d;
      vga_vs_q      <= vga_vs_d;
    end
  end

  assign hdata       = hcount_q;
  assign vdata       = vcount_q;
  assign vga_r       = rgb_q[3*DEPTH-1 -: DEPTH];
  assign vga_g       = rgb_q[2*DEPTH-1 -: DEPTH];
  assign vga_b       = rgb_q[DEPTH-1:0];
  assign vga_hs      = vga_hs_q;
  assign vga_vs      = vga_vs_q;
  assign frame_start = frame_start_q;

endmodule
